// File: rtl/mem_arbiter.sv
// Single-port memory arbiter and access sequencer shared by instruction fetch and the MEM stage.
// Optional fetch starvation guard enabled by defining MEM_ARB_STARVE_GUARD_EN.
module mem_arbiter #(
  parameter int unsigned ADDR_W     = 16,
  parameter int unsigned DATA_W     = 16,
  parameter int unsigned MEM_LAT    = 1,
  parameter int unsigned STARVE_MAX = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_if_req,
  input  logic [ADDR_W-1:0] i_if_addr,
  output logic              o_if_gnt,
  output logic              o_if_valid,
  output logic [DATA_W-1:0] o_if_rdata,
  input  logic              i_d_req,
  input  logic              i_d_we,
  input  logic [ADDR_W-1:0] i_d_addr,
  input  logic [DATA_W-1:0] i_d_wdata,
  output logic              o_d_gnt,
  output logic              o_d_valid,
  output logic [DATA_W-1:0] o_d_rdata,
  output logic              o_mem_en,
  output logic              o_mem_we,
  output logic [ADDR_W-1:0] o_mem_addr,
  output logic [DATA_W-1:0] o_mem_wdata,
  input  logic [DATA_W-1:0] i_mem_rdata,
  output logic              o_stall
);

  if (MEM_LAT < 1 || MEM_LAT > 4) begin : g_bad_lat
    $error("mem_arbiter: MEM_LAT must be in 1..4");
  end
  if (STARVE_MAX < 1 || STARVE_MAX > 15) begin : g_bad_starve
    $error("mem_arbiter: STARVE_MAX must be in 1..15");
  end

  typedef enum logic [1:0] {StIdle, StRdWait, StDone} state_e;

  state_e            state_q;
  logic              owner_q;  // 1 = data port owns the outstanding read
  logic [2:0]        cnt_q;
  logic              if_valid_q, d_valid_q;
  logic [DATA_W-1:0] if_rdata_q, d_rdata_q;

  logic can_grant, pick_fetch, if_gnt, d_gnt;

`ifdef MEM_ARB_STARVE_GUARD_EN
  logic [3:0] starve_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      starve_q <= 4'd0;
    end else if (if_gnt) begin
      starve_q <= 4'd0;
    end else if (d_gnt && i_if_req) begin
      starve_q <= starve_q + 4'd1;
    end
  end

  assign pick_fetch = i_if_req && (!i_d_req || (starve_q == 4'(STARVE_MAX)));
`else
  assign pick_fetch = i_if_req && !i_d_req;
`endif

  // DONE arbitrates like IDLE so accesses can run back-to-back.
  assign can_grant = !rst && (state_q != StRdWait);
  assign if_gnt    = can_grant && pick_fetch;
  assign d_gnt     = can_grant && i_d_req && !pick_fetch;

  always_comb begin
    o_mem_addr  = '0;
    o_mem_wdata = '0;
    o_mem_we    = 1'b0;
    if (d_gnt) begin
      o_mem_addr = i_d_addr;
      o_mem_we   = i_d_we;
      if (i_d_we) o_mem_wdata = i_d_wdata;
    end else if (if_gnt) begin
      o_mem_addr = i_if_addr;
    end
  end

  assign o_mem_en   = if_gnt || d_gnt;
  assign o_if_gnt   = if_gnt;
  assign o_d_gnt    = d_gnt;
  assign o_if_valid = if_valid_q;
  assign o_d_valid  = d_valid_q;
  assign o_if_rdata = if_rdata_q;
  assign o_d_rdata  = d_rdata_q;
  assign o_stall    = !rst && ((i_d_req && !d_valid_q) || (state_q == StRdWait && owner_q));

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= StIdle;
      owner_q    <= 1'b0;
      cnt_q      <= 3'd0;
      if_valid_q <= 1'b0;
      d_valid_q  <= 1'b0;
      if_rdata_q <= '0;
      d_rdata_q  <= '0;
    end else begin
      if_valid_q <= 1'b0;
      d_valid_q  <= 1'b0;
      case (state_q)
        StRdWait: begin
          if (cnt_q == 3'd1) begin
            cnt_q   <= 3'd0;
            state_q <= StDone;
            if (owner_q) begin
              d_rdata_q <= i_mem_rdata;
              d_valid_q <= 1'b1;
            end else begin
              if_rdata_q <= i_mem_rdata;
              if_valid_q <= 1'b1;
            end
          end else begin
            cnt_q <= cnt_q - 3'd1;
          end
        end
        StIdle, StDone: begin
          if (if_gnt) begin
            owner_q <= 1'b0;
            cnt_q   <= 3'(MEM_LAT);
            state_q <= StRdWait;
          end else if (d_gnt) begin
            owner_q <= 1'b1;
            if (i_d_we) begin
              d_valid_q <= 1'b1;
              state_q   <= StDone;
            end else begin
              cnt_q   <= 3'(MEM_LAT);
              state_q <= StRdWait;
            end
          end else begin
            state_q <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Table-driven bench for mem_arbiter: three instances with MEM_LAT 1, 2 and 3 share the stimulus;
// each vector is checked against the instance it names.
module tb_mem_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        if_req, d_req, d_we;
  logic [15:0] if_addr, d_addr, d_wdata;
  logic [70:0] outs [3];

  always #5 clk = ~clk;

  function automatic logic [15:0] preload(input logic [15:0] a);
    case (a)
      16'h0010: return 16'hBEEF;
      16'h0020: return 16'h1111;
      16'h0030: return 16'h3333;
      16'h0060: return 16'h6666;
      16'h0080: return 16'h00A5;
      default:  return 16'h0000;
    endcase
  endfunction

  for (genvar g = 0; g < 3; g++) begin : g_dut
    localparam int unsigned Lat = g + 1;
    logic        if_gnt, if_valid, d_gnt, d_valid, mem_en, mem_we, stall;
    logic [15:0] if_rdata, d_rdata, mem_addr, mem_wdata, mem_rdata;
    logic [15:0] pipe [4];
    logic        st_vld = 1'b0;
    logic [15:0] st_addr = 16'h0;
    logic [15:0] st_data = 16'h0;

    // Memory model: one remembered store over a fixed preload, read data after Lat cycles.
    always @(posedge clk) begin
      if (mem_en && mem_we) begin
        st_vld  <= 1'b1;
        st_addr <= mem_addr;
        st_data <= mem_wdata;
      end
      pipe[0] <= (mem_en && !mem_we) ?
                 ((st_vld && mem_addr == st_addr) ? st_data : preload(mem_addr)) : 16'hDEAD;
      for (int k = 1; k < 4; k++) pipe[k] <= pipe[k-1];
    end
    assign mem_rdata = pipe[Lat-1];

    mem_arbiter #(.ADDR_W(16), .DATA_W(16), .MEM_LAT(Lat), .STARVE_MAX(4)) u_dut (
      .clk        (clk),
      .rst        (rst),
      .i_if_req   (if_req),
      .i_if_addr  (if_addr),
      .o_if_gnt   (if_gnt),
      .o_if_valid (if_valid),
      .o_if_rdata (if_rdata),
      .i_d_req    (d_req),
      .i_d_we     (d_we),
      .i_d_addr   (d_addr),
      .i_d_wdata  (d_wdata),
      .o_d_gnt    (d_gnt),
      .o_d_valid  (d_valid),
      .o_d_rdata  (d_rdata),
      .o_mem_en   (mem_en),
      .o_mem_we   (mem_we),
      .o_mem_addr (mem_addr),
      .o_mem_wdata(mem_wdata),
      .i_mem_rdata(mem_rdata),
      .o_stall    (stall)
    );

    assign outs[g] = {if_gnt, if_valid, if_rdata, d_gnt, d_valid, d_rdata,
                      mem_en, mem_we, mem_addr, mem_wdata, stall};
  end

  typedef struct {
    string       tag;
    int          sel;
    bit          chk;
    logic        rst, ifr;
    logic [15:0] ifa;
    logic        dr, dwe;
    logic [15:0] da, dwd;
    logic [70:0] exp;
  } vec_t;

  vec_t vecs[$];
  int   n_pass = 0;
  int   n_total = 0;
  bit   seen;

  function automatic logic [70:0] o(input logic ig, iv, input logic [15:0] ird,
                                    input logic dg, dv, input logic [15:0] drd,
                                    input logic me, mw, input logic [15:0] ma, mwd,
                                    input logic st);
    return {ig, iv, ird, dg, dv, drd, me, mw, ma, mwd, st};
  endfunction

  task automatic add(input string tag, input int sel, input bit chk, input logic r,
                     input logic ifr, input logic [15:0] ifa, input logic dr, dwe,
                     input logic [15:0] da, dwd, input logic [70:0] exp);
    vec_t v;
    v.tag = tag; v.sel = sel; v.chk = chk; v.rst = r; v.ifr = ifr; v.ifa = ifa;
    v.dr = dr; v.dwe = dwe; v.da = da; v.dwd = dwd; v.exp = exp;
    vecs.push_back(v);
  endtask

  task automatic add_reset(input string tag, input int sel);
    add({tag, "_rst0"}, sel, 0, 1, 0, 0, 0, 0, 0, 0, '0);
    add({tag, "_rst"},  sel, 1, 1, 0, 0, 0, 0, 0, 0, '0);
  endtask

  initial begin
    rst = 1'b1; if_req = 1'b0; d_req = 1'b0; d_we = 1'b0;
    if_addr = '0; d_addr = '0; d_wdata = '0;

    // Single fetch, MEM_LAT=2
    add_reset("A", 2);
    add("A_idle", 2, 1, 0, 0, 0,     0, 0, 0, 0, '0);
    add("A_gnt",  2, 1, 0, 1, 'h10,  0, 0, 0, 0, o(1,0,0, 0,0,0, 1,0,'h10,0, 0));
    add("A_w1",   2, 1, 0, 0, 0,     0, 0, 0, 0, '0);
    add("A_w2",   2, 1, 0, 0, 0,     0, 0, 0, 0, '0);
    add("A_vld",  2, 1, 0, 0, 0,     0, 0, 0, 0, o(0,1,'hBEEF, 0,0,0, 0,0,0,0, 0));
    add("A_hold", 2, 1, 0, 0, 0,     0, 0, 0, 0, o(0,0,'hBEEF, 0,0,0, 0,0,0,0, 0));

    // Store beats a pending fetch, then read the stored word back, MEM_LAT=1
    add_reset("B", 1);
    add("B_st",  1, 1, 0, 1, 'h20, 1, 1, 'h40, 'h1234,
        o(0,0,0, 1,0,0, 1,1,'h40,'h1234, 1));
    add("B_fg",  1, 1, 0, 1, 'h20, 0, 0, 0, 0, o(1,0,0, 0,1,0, 1,0,'h20,0, 0));
    add("B_fw",  1, 1, 0, 0, 0,    0, 0, 0, 0, '0);
    add("B_ld",  1, 1, 0, 0, 0,    1, 0, 'h40, 0, o(0,1,'h1111, 1,0,0, 1,0,'h40,0, 1));
    add("B_lw",  1, 1, 0, 0, 0,    0, 0, 0, 0, o(0,0,'h1111, 0,0,0, 0,0,0,0, 1));
    add("B_lv",  1, 1, 0, 0, 0,    0, 0, 0, 0, o(0,0,'h1111, 0,1,'h1234, 0,0,0,0, 0));

    // Load 0x0080 with fetch waiting, MEM_LAT=1
    add("C_ld",  1, 1, 0, 1, 'h30, 1, 0, 'h80, 0, o(0,0,'h1111, 1,0,'h1234, 1,0,'h80,0, 1));
    add("C_w",   1, 1, 0, 1, 'h30, 0, 0, 0, 0, o(0,0,'h1111, 0,0,'h1234, 0,0,0,0, 1));
    add("C_v",   1, 1, 0, 1, 'h30, 0, 0, 0, 0, o(1,0,'h1111, 0,1,'h00A5, 1,0,'h30,0, 0));
    add("C_fw",  1, 1, 0, 0, 0,    0, 0, 0, 0, o(0,0,'h1111, 0,0,'h00A5, 0,0,0,0, 0));
    add("C_fv",  1, 1, 0, 0, 0,    0, 0, 0, 0, o(0,1,'h3333, 0,0,'h00A5, 0,0,0,0, 0));

    // Continuous stores with fetch requesting every cycle
    add_reset("D", 1);
    add("D_g1", 1, 1, 0, 1, 'h60, 1, 1, 'h50, 'h5555, o(0,0,0, 1,0,0, 1,1,'h50,'h5555, 1));
    add("D_g2", 1, 1, 0, 1, 'h60, 1, 1, 'h50, 'h5555, o(0,0,0, 1,1,0, 1,1,'h50,'h5555, 0));
    add("D_g3", 1, 1, 0, 1, 'h60, 1, 1, 'h50, 'h5555, o(0,0,0, 1,1,0, 1,1,'h50,'h5555, 0));
    add("D_g4", 1, 1, 0, 1, 'h60, 1, 1, 'h50, 'h5555, o(0,0,0, 1,1,0, 1,1,'h50,'h5555, 0));
`ifdef MEM_ARB_STARVE_GUARD_EN
    add("D_fg", 1, 1, 0, 1, 'h60, 1, 1, 'h50, 'h5555, o(1,0,0, 0,1,0, 1,0,'h60,0, 0));
    add("D_fw", 1, 1, 0, 1, 'h60, 1, 1, 'h50, 'h5555, o(0,0,0, 0,0,0, 0,0,0,0, 1));
    add("D_r1", 1, 1, 0, 1, 'h60, 1, 1, 'h50, 'h5555,
        o(0,1,'h6666, 1,0,0, 1,1,'h50,'h5555, 1));
    add("D_r2", 1, 1, 0, 1, 'h60, 1, 1, 'h50, 'h5555,
        o(0,0,'h6666, 1,1,0, 1,1,'h50,'h5555, 0));
`else
    add("D_g5", 1, 1, 0, 1, 'h60, 1, 1, 'h50, 'h5555, o(0,0,0, 1,1,0, 1,1,'h50,'h5555, 0));
    add("D_g6", 1, 1, 0, 1, 'h60, 1, 1, 'h50, 'h5555, o(0,0,0, 1,1,0, 1,1,'h50,'h5555, 0));
    add("D_g7", 1, 1, 0, 1, 'h60, 1, 1, 'h50, 'h5555, o(0,0,0, 1,1,0, 1,1,'h50,'h5555, 0));
    add("D_g8", 1, 1, 0, 1, 'h60, 1, 1, 'h50, 'h5555, o(0,0,0, 1,1,0, 1,1,'h50,'h5555, 0));
`endif

    // Reset in the middle of a MEM_LAT=3 load abandons it
    add_reset("E", 3);
    add("E_ld",  3, 1, 0, 0, 0,    1, 0, 'h80, 0, o(0,0,0, 1,0,0, 1,0,'h80,0, 1));
    add("E_w",   3, 1, 0, 0, 0,    0, 0, 0, 0, o(0,0,0, 0,0,0, 0,0,0,0, 1));
    add("E_rst", 3, 0, 1, 0, 0,    0, 0, 0, 0, '0);
    add("E_fg",  3, 1, 0, 1, 'h10, 0, 0, 0, 0, o(1,0,0, 0,0,0, 1,0,'h10,0, 0));
    add("E_n1",  3, 1, 0, 0, 0,    0, 0, 0, 0, '0);
    add("E_n2",  3, 1, 0, 0, 0,    0, 0, 0, 0, '0);
    add("E_n3",  3, 1, 0, 0, 0,    0, 0, 0, 0, '0);
    add("E_fv",  3, 1, 0, 0, 0,    0, 0, 0, 0, o(0,1,'hBEEF, 0,0,0, 0,0,0,0, 0));

    // Data request withdrawn before grant while fetch waits
    add_reset("F", 1);
    add("F_fg",   1, 1, 0, 1, 'h20, 0, 0, 0, 0,     o(1,0,0, 0,0,0, 1,0,'h20,0, 0));
    add("F_pend", 1, 1, 0, 1, 'h30, 1, 0, 'h80, 0,  o(0,0,0, 0,0,0, 0,0,0,0, 1));
    add("F_drop", 1, 1, 0, 1, 'h30, 0, 0, 0, 0,     o(1,1,'h1111, 0,0,0, 1,0,'h30,0, 0));
    add("F_w",    1, 1, 0, 0, 0,    0, 0, 0, 0,     o(0,0,'h1111, 0,0,0, 0,0,0,0, 0));
    add("F_v",    1, 1, 0, 0, 0,    0, 0, 0, 0,     o(0,1,'h3333, 0,0,0, 0,0,0,0, 0));

    foreach (vecs[i]) begin
      @(negedge clk);
      rst = vecs[i].rst; if_req = vecs[i].ifr; if_addr = vecs[i].ifa;
      d_req = vecs[i].dr; d_we = vecs[i].dwe; d_addr = vecs[i].da; d_wdata = vecs[i].dwd;
      #3;
      if (vecs[i].chk) begin
        n_total++;
        if (outs[vecs[i].sel-1] === vecs[i].exp) begin
          n_pass++;
        end else begin
          $display("FAIL %s (lat%0d) got {ig,iv,ird,dg,dv,drd,me,mw,ma,mwd,st}=%h required %h",
                   vecs[i].tag, vecs[i].sel, outs[vecs[i].sel-1], vecs[i].exp);
        end
      end
    end

    // Reset state of every instance
    @(negedge clk);
    rst = 1'b1; if_req = 1'b0; if_addr = '0;
    d_req = 1'b0; d_we = 1'b0; d_addr = '0; d_wdata = '0;
    @(negedge clk);
    #3;
    for (int k = 0; k < 3; k++) begin
      n_total++;
      if (outs[k] === '0) begin
        n_pass++;
      end else begin
        $display("FAIL reset state (lat%0d) got %h required all zero", k + 1, outs[k]);
      end
    end

    // Bounded wait for the fetch completion on the MEM_LAT=3 instance
    @(negedge clk);
    rst = 1'b0; if_req = 1'b1; if_addr = 16'h0010;
    @(negedge clk);
    if_req = 1'b0; if_addr = '0;
    seen = 1'b0;
    for (int c = 0; c < 8 && !seen; c++) begin
      #3;
      if (outs[2][69] === 1'b1) seen = 1'b1;
      else @(negedge clk);
    end
    n_total++;
    if (seen && outs[2][68:53] === 16'hBEEF) begin
      n_pass++;
    end else begin
      $display("FAIL wait for fetch valid (lat3) expired or wrong data: seen=%0b rdata=%h",
               seen, outs[2][68:53]);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
